eval_dispatch: RTL
==================

# eval_dispatch

Initiator side of the evaluator handshake. Accepts one board request at a time from the search logic and drives the evaluator's board, board_valid, clear_eval and white_to_move inputs. It waits for eval_valid, then blends the midgame and endgame scores by game phase into a single side-to-move-relative score, and returns it through a valid/ready response port. It sits between the search/move-generation control and one evaluator instance.

## Interface
- EVAL_WIDTH, 24: signed width of evaluator scores and of rsp_score.
- PHASE_SHIFT, 5: right shift applied to total material to form the phase.
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before the block aborts.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the block can accept a request (IDLE only).
- req_board  in  BOARD_WIDTH  board to evaluate.
- req_white_to_move  in  1  side to move for the request.
- eval_board  out  BOARD_WIDTH  board driven to the evaluator.
- eval_board_valid  out  1  one-cycle start pulse to the evaluator.
- eval_clear  out  1  one-cycle clear pulse to the evaluator.
- eval_white_to_move  out  1  side to move driven to the evaluator.
- eval_valid  in  1  evaluator result is valid; remains high until cleared.
- eval_mg, eval_eg  in  EVAL_WIDTH signed  evaluator midgame and endgame scores.
- eval_insufficient  in  1  evaluator reports insufficient material.
- material_white, material_black  in  32  non-king material totals from the evaluator.
- rsp_valid  out  1  a response is presented.
- rsp_ready  in  1  the consumer accepts the response.
- rsp_score  out  EVAL_WIDTH signed  blended score relative to the side to move.
- rsp_insufficient  out  1  the evaluator flagged a draw by insufficient material.
- rsp_timeout  out  1  the evaluator did not respond within TIMEOUT_CYCLES.

## Operation
- States: IDLE, ISSUE, WAIT, BLEND, RESP, CLEAR.
- IDLE: req_ready=1.
  - On req_valid, capture req_board into eval_board and req_white_to_move into eval_white_to_move, then go to ISSUE.
- ISSUE: eval_board_valid=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- eval_board and eval_white_to_move stay stable from capture until the cycle after CLEAR.
- WAIT:
  - The wait counter increments each cycle.
  - eval_valid is ignored on the first WAIT cycle, so a stale valid cannot be taken.
  - On eval_valid, register eval_mg, eval_eg, eval_insufficient and the material sum, then go to BLEND.
  - If the counter reaches TIMEOUT_CYCLES first, set the timeout flag, force the score to 0, and go to RESP.
  - If eval_valid and the timeout occur in the same cycle, eval_valid wins.
- BLEND (one cycle):
  - Phase: phase = min((material_white + material_black) >> PHASE_SHIFT, 256). The sum is taken at 33 bits, with no wrap.
  - Blend: t = (mg*phase + eg*(256 - phase)) >>> 8. Intermediates are signed at EVAL_WIDTH+10 bits. The shift is arithmetic, so results round toward negative infinity.
  - If eval_white_to_move is 0, negate t.
  - Saturate t to the EVAL_WIDTH signed range. Negating the most negative value gives the maximum positive value.
  - If the registered eval_insufficient is 1, the score is 0.
- RESP:
  - rsp_valid=1. rsp_score, rsp_insufficient and rsp_timeout are held stable.
  - When rsp_valid and rsp_ready are both high, go to CLEAR.
- CLEAR: eval_clear=1 for one cycle. Clear all response flags. Go to IDLE.
- A new request is never accepted before CLEAR completes; only one request is in flight.

## Timing
- Reset values:
  - All outputs are 0, including req_ready, eval_board and rsp_score.
  - The state is IDLE. req_ready rises on the first clock after reset deasserts.
- Request accepted at cycle 0 (IDLE, req_valid=1):
  - ISSUE at cycle 1, with eval_board_valid high at cycle 1.
  - WAIT from cycle 2.
- eval_valid sampled high at cycle N in WAIT: BLEND at N+1, rsp_valid high from N+2.
- With an evaluator latency of 7, eval_valid is first seen at cycle 8 and rsp_valid rises at cycle 10.
- rsp_ready already high: RESP lasts 1 cycle, CLEAR follows at the next cycle, and IDLE (req_ready=1) one cycle after that.
- Timeout: rsp_valid rises the cycle after the counter reaches TIMEOUT_CYCLES.
- Reset asserted in any state:
  - Immediately returns to IDLE and zeroes all outputs.
  - No eval_clear is issued. The evaluator is reset on the same reset net.

## Test plan
- Full phase:
  - Stimulus: mg=100, eg=20, material_white=4000, material_black=4200, white to move.
  - Required: phase=256, rsp_score=100.
- Half phase:
  - Stimulus: mg=100, eg=20, material sum 4096, white to move.
  - Required: phase=128, rsp_score=60.
  - Same case with black to move: rsp_score=-60.
- Rounding:
  - Stimulus: mg=-3, eg=0, phase=128.
  - Required: rsp_score=-2 (floor).
- Insufficient material:
  - Stimulus: eval_insufficient=1, mg=500.
  - Required: rsp_score=0, rsp_insufficient=1, then one eval_clear pulse.
- Timeout and backpressure:
  - Stimulus: eval_valid held 0, with TIMEOUT_CYCLES=64.
  - Required: rsp_valid at cycle 66, rsp_timeout=1, score 0.
  - Hold rsp_ready low for 5 cycles: outputs stay stable, and eval_clear pulses once after the handshake.
- Reset mid-WAIT:
  - Stimulus: assert reset at cycle 5.
  - Required: all outputs 0 asynchronously, then a fresh request completes normally with no stale result.

Source files
------------

// File: rtl/eval_dispatch.sv
// Initiator side of the evaluator handshake: issues one board at a time, waits for
// the result (or a timeout) and returns a phase-blended, side-to-move-relative score.
module eval_dispatch #(
    parameter int BOARD_WIDTH    = 64,
    parameter int EVAL_WIDTH     = 24,
    parameter int PHASE_SHIFT    = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [BOARD_WIDTH-1:0]       req_board,
    input  logic                         req_white_to_move,
    output logic [BOARD_WIDTH-1:0]       eval_board,
    output logic                         eval_board_valid,
    output logic                         eval_clear,
    output logic                         eval_white_to_move,
    input  logic                         eval_valid,
    input  logic signed [EVAL_WIDTH-1:0] eval_mg,
    input  logic signed [EVAL_WIDTH-1:0] eval_eg,
    input  logic                         eval_insufficient,
    input  logic [31:0]                  material_white,
    input  logic [31:0]                  material_black,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [EVAL_WIDTH-1:0] rsp_score,
    output logic                         rsp_insufficient,
    output logic                         rsp_timeout
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BLEND, RESP, CLEAR} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW    = EVAL_WIDTH + 10;
    localparam logic signed [BW-1:0] SAT_MAX = BW'((64'sd1 <<< (EVAL_WIDTH - 1)) - 64'sd1);
    localparam logic signed [BW-1:0] SAT_MIN = BW'(-(64'sd1 <<< (EVAL_WIDTH - 1)));

    state_t state_q, state_d;
    logic                         started_q, started_d;
    logic [BOARD_WIDTH-1:0]       board_q, board_d;
    logic                         wtm_q, wtm_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [EVAL_WIDTH-1:0] mg_q, mg_d;
    logic signed [EVAL_WIDTH-1:0] eg_q, eg_d;
    logic                         insuf_q, insuf_d;
    logic [32:0]                  mat_q, mat_d;
    logic signed [EVAL_WIDTH-1:0] score_q, score_d;
    logic                         rsp_insuf_q, rsp_insuf_d;
    logic                         rsp_tmo_q, rsp_tmo_d;

    logic                         take_result;
    logic                         timed_out;
    logic [32:0]                  phase_raw;
    logic [8:0]                   phase;
    logic [9:0]                   inv_phase;
    logic signed [BW-1:0]         mg_x, eg_x, ph_x, inv_x, acc, t, t_neg, t_sat;
    logic signed [EVAL_WIDTH-1:0] blend_score;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first WAIT cycle (cnt_q == 0) ignores eval_valid so a stale result is never taken.
    assign take_result = (state_q == WAIT) && eval_valid && (cnt_q != '0);
    assign timed_out   = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (started_q && req_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (take_result) begin
                    state_d = BLEND;
                end else if (timed_out) begin
                    state_d = RESP;
                end
            end
            BLEND: state_d = RESP;
            RESP:  if (rsp_ready) state_d = CLEAR;
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready          = (state_q == IDLE) && started_q;
        eval_board_valid   = (state_q == ISSUE);
        eval_clear         = (state_q == CLEAR);
        rsp_valid          = (state_q == RESP);
        eval_board         = board_q;
        eval_white_to_move = wtm_q;
        rsp_score          = score_q;
        rsp_insufficient   = rsp_insuf_q;
        rsp_timeout        = rsp_tmo_q;
    end

    // Material sum is kept at 33 bits so two large totals cannot wrap the phase to zero.
    always_comb begin
        phase_raw = mat_q >> PHASE_SHIFT;
        phase     = (phase_raw > 33'd256) ? 9'd256 : phase_raw[8:0];
        inv_phase = 10'd256 - {1'b0, phase};
        mg_x      = BW'(mg_q);
        eg_x      = BW'(eg_q);
        ph_x      = BW'(phase);
        inv_x     = BW'(inv_phase);
        acc       = mg_x * ph_x + eg_x * inv_x;
        t         = acc >>> 8;
        t_neg     = wtm_q ? t : -t;
        if (t_neg > SAT_MAX) begin
            t_sat = SAT_MAX;
        end else if (t_neg < SAT_MIN) begin
            t_sat = SAT_MIN;
        end else begin
            t_sat = t_neg;
        end
        blend_score = insuf_q ? '0 : EVAL_WIDTH'(t_sat);
    end

    always_comb begin
        started_d   = 1'b1;
        board_d     = board_q;
        wtm_d       = wtm_q;
        cnt_d       = cnt_q;
        mg_d        = mg_q;
        eg_d        = eg_q;
        insuf_d     = insuf_q;
        mat_d       = mat_q;
        score_d     = score_q;
        rsp_insuf_d = rsp_insuf_q;
        rsp_tmo_d   = rsp_tmo_q;
        unique case (state_q)
            IDLE: begin
                if (started_q && req_valid) begin
                    board_d = req_board;
                    wtm_d   = req_white_to_move;
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (take_result) begin
                    mg_d    = eval_mg;
                    eg_d    = eval_eg;
                    insuf_d = eval_insufficient;
                    mat_d   = {1'b0, material_white} + {1'b0, material_black};
                end else if (timed_out) begin
                    rsp_tmo_d   = 1'b1;
                    rsp_insuf_d = 1'b0;
                    score_d     = '0;
                end
            end
            BLEND: begin
                score_d     = blend_score;
                rsp_insuf_d = insuf_q;
                rsp_tmo_d   = 1'b0;
            end
            RESP: ;
            CLEAR: begin
                score_d     = '0;
                rsp_insuf_d = 1'b0;
                rsp_tmo_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q   <= 1'b0;
            board_q     <= '0;
            wtm_q       <= 1'b0;
            cnt_q       <= '0;
            mg_q        <= '0;
            eg_q        <= '0;
            insuf_q     <= 1'b0;
            mat_q       <= '0;
            score_q     <= '0;
            rsp_insuf_q <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            started_q   <= started_d;
            board_q     <= board_d;
            wtm_q       <= wtm_d;
            cnt_q       <= cnt_d;
            mg_q        <= mg_d;
            eg_q        <= eg_d;
            insuf_q     <= insuf_d;
            mat_q       <= mat_d;
            score_q     <= score_d;
            rsp_insuf_q <= rsp_insuf_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

endmodule
